// File: rtl/gol_pkg.sv
// gol_pkg: shared constants, state encoding and LFSR helper for the Game of Life scheduler.
package gol_pkg;
    localparam int COLS_DEF = 32;
    localparam int ROWS_DEF = 24;
    localparam int CELLS_DEF = COLS_DEF * ROWS_DEF;
    localparam int ADDR_W_DEF = $clog2(CELLS_DEF);

    localparam int K_RUN = 0;
    localparam int K_STEP = 1;
    localparam int K_CLR = 2;
    localparam int K_SEED = 3;

    // Taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {IDLE, START, BUSY, SWAP, FILL, FILL_SWAP} state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/key_edge.sv
// key_edge: rising-edge detector for synchronized key levels.
module key_edge #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] key,
    output logic [W-1:0] rise
);
    logic [W-1:0] key_q;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) key_q <= '0;
        else key_q <= key;

    assign rise = key & ~key_q;
endmodule

// File: rtl/gol_scheduler.sv
// gol_scheduler: bank ownership, vblank pacing of the update engine and clear/seed fills.
module gol_scheduler import gol_pkg::*; #(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int GEN_DIV = 30,
    localparam int CELLS = COLS * ROWS,
    localparam int ADDR_W = $clog2(CELLS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        key,
    input  logic              frame_start,
    input  logic              eng_done,
    output logic              eng_start,
    output logic              eng_src_bank,
    output logic              disp_bank,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic              fill_data,
    output logic              running,
    output logic [15:0]       gen_count,
    output logic              overrun
);
    localparam int FW = $clog2(GEN_DIV + 1);

    logic [3:0] rise;
    state_t state;
    logic [15:0] lfsr;
    logic [FW-1:0] frm_cnt;
    logic pend_clr, pend_seed, pend_step, pend_gen, fill_clr;
    logic take, gen_take, wrap;

    key_edge #(.W(4)) u_key (.clk(clk), .reset_n(reset_n), .key(key), .rise(rise));

    always_comb begin
        take = (state == IDLE) && frame_start;
        gen_take = take && !pend_clr && !pend_seed && (pend_gen || pend_step);
        wrap = frame_start && running && (frm_cnt == FW'(GEN_DIV - 1));
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            lfsr <= LFSR_SEED;
            frm_cnt <= '0;
            {pend_clr, pend_seed, pend_step, pend_gen, fill_clr} <= '0;
            {eng_start, eng_src_bank, disp_bank, fill_we, fill_data, running, overrun} <= '0;
            fill_addr <= '0;
            gen_count <= '0;
        end else begin
            lfsr <= lfsr_next(lfsr);
            eng_start <= gen_take;
            if (rise[K_RUN]) running <= !running;
            if (!running || rise[K_RUN]) frm_cnt <= '0;
            else if (frame_start) frm_cnt <= wrap ? '0 : frm_cnt + FW'(1);
            // Consumption first so a same-cycle new event still latches.
            if (take && pend_clr) pend_clr <= 1'b0;
            if (rise[K_CLR]) pend_clr <= 1'b1;
            if (take && !pend_clr && pend_seed) pend_seed <= 1'b0;
            if (rise[K_SEED]) pend_seed <= 1'b1;
            if (gen_take) {pend_gen, pend_step} <= 2'b00;
            if (rise[K_STEP] && !running) pend_step <= 1'b1;
            if (wrap) begin
                if (pend_gen && !gen_take) overrun <= 1'b1;
                else pend_gen <= 1'b1;
            end
            case (state)
                IDLE:
                    if (take && (pend_clr || pend_seed)) begin
                        state <= FILL;
                        fill_we <= 1'b1;
                        fill_addr <= '0;
                        fill_clr <= pend_clr;
                        fill_data <= !pend_clr & lfsr[0];
                    end else if (gen_take) begin
                        state <= START;
                        eng_src_bank <= disp_bank;
                    end
                START: state <= BUSY;
                BUSY: if (eng_done) state <= SWAP;
                SWAP: begin
                    disp_bank <= !disp_bank;
                    gen_count <= gen_count + 16'd1;
                    state <= IDLE;
                end
                FILL:
                    if (fill_addr == ADDR_W'(CELLS - 1)) begin
                        fill_we <= 1'b0;
                        fill_addr <= '0;
                        fill_data <= 1'b0;
                        state <= FILL_SWAP;
                    end else begin
                        fill_addr <= fill_addr + ADDR_W'(1);
                        fill_data <= !fill_clr & lfsr[0];
                    end
                FILL_SWAP: begin
                    disp_bank <= !disp_bank;
                    gen_count <= '0;
                    if (fill_clr) begin
                        overrun <= 1'b0;
                        frm_cnt <= '0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_gol_scheduler.sv
// tb_gol_scheduler: directed checks of pacing, stepping, fills, overrun and async reset.
module tb_gol_scheduler;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] key = 4'h0;
    logic frame_start = 1'b0;
    logic done3 = 1'b0, done1 = 1'b0;

    logic es3, src3, disp3, we3, data3, run3, ovr3;
    logic [9:0] addr3;
    logic [15:0] gen3;
    logic es1, src1, disp1, we1, data1, run1, ovr1;
    logic [9:0] addr1;
    logic [15:0] gen1;

    int checks = 0, errors = 0;
    int n_start3 = 0;
    int fill_bad = 0, fill_run = 0, last_run = 0, ones = 0;
    logic prev_we = 1'b0, fill_bank = 1'b0, seed_mode = 1'b0;
    logic [15:0] m, mp;
    logic cap3, cap1;

    always #5 clk = ~clk;

    gol_scheduler #(.COLS(32), .ROWS(24), .GEN_DIV(3)) u3 (
        .clk(clk), .reset_n(reset_n), .key(key), .frame_start(frame_start), .eng_done(done3),
        .eng_start(es3), .eng_src_bank(src3), .disp_bank(disp3), .fill_we(we3), .fill_addr(addr3),
        .fill_data(data3), .running(run3), .gen_count(gen3), .overrun(ovr3));

    gol_scheduler #(.COLS(32), .ROWS(24), .GEN_DIV(1)) u1 (
        .clk(clk), .reset_n(reset_n), .key(key), .frame_start(frame_start), .eng_done(done1),
        .eng_start(es1), .eng_src_bank(src1), .disp_bank(disp1), .fill_we(we1), .fill_addr(addr1),
        .fill_data(data1), .running(run1), .gen_count(gen1), .overrun(ovr1));

    // Reference LFSR; mp is the value the DUT used at the most recent edge.
    always @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            m <= 16'hACE1;
            mp <= 16'h0;
        end else begin
            mp <= m;
            m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        end

    always @(posedge clk) if (es3) n_start3 <= n_start3 + 1;

    // Engine stand-in for u3: eng_done five cycles after eng_start.
    always @(posedge clk)
        if (es3 && reset_n) begin
            repeat (5) @(posedge clk);
            #1 done3 = 1'b1;
            @(posedge clk);
            #1 done3 = 1'b0;
        end

    always @(negedge clk) begin
        if (we3) begin
            if (!prev_we) begin
                fill_run = 0;
                fill_bank = ~disp3;
            end
            if (addr3 != 10'(fill_run)) fill_bad++;
            if (data3 != (seed_mode ? mp[0] : 1'b0)) fill_bad++;
            if (~disp3 != fill_bank) fill_bad++;
            if (data3) ones++;
            fill_run++;
        end else if (prev_we) last_run = fill_run;
        prev_we = we3;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key = k;
        tick(3);
        key = 4'h0;
        tick(1);
    endtask

    task automatic frame(input int gap);
        frame_start = 1'b1;
        tick(1);
        cap3 = es3;
        cap1 = es1;
        frame_start = 1'b0;
        tick(gap);
    endtask

    initial begin
        int s0, b0, o0;
        tick(3);
        check("rst_es", es3, 0);
        check("rst_src", src3, 0);
        check("rst_disp", disp3, 0);
        check("rst_we", we3, 0);
        check("rst_addr", addr3, 0);
        check("rst_data", data3, 0);
        check("rst_run", run3, 0);
        check("rst_gen", gen3, 0);
        check("rst_ovr", ovr3, 0);
        reset_n = 1'b1;
        tick(2);

        s0 = n_start3;
        for (int i = 0; i < 100; i++) frame(3);
        check("idle_starts", n_start3 - s0, 0);
        check("idle_disp", disp3, 0);
        check("idle_gen", gen3, 0);

        press(4'b0001);
        check("run_on", run3, 1);
        for (int f = 1; f <= 10; f++) begin
            frame(15);
            check($sformatf("run_es_f%0d", f), cap3, (f % 3 == 1 && f > 1) ? 1 : 0);
            if (f == 4) check("run_disp_g1", {disp3, gen3}, {1'b1, 16'd1});
            if (f == 7) check("run_disp_g2", {disp3, gen3}, {1'b0, 16'd2});
        end
        check("run_gen3", gen3, 3);
        check("run_disp3", disp3, 1);
        check("run_src3", src3, 0);

        press(4'b0001);
        check("paused", run3, 0);
        press(4'b0010);
        frame(15);
        check("step_es", cap3, 1);
        check("step_src", src3, 1);
        check("step_gen", gen3, 4);
        check("step_disp", disp3, 0);
        frame(15);
        check("step_once", cap3, 0);
        press(4'b0001);
        press(4'b0010);
        frame(15);
        check("step_running_es", cap3, 0);
        press(4'b0001);
        check("step_running_gen", gen3, 4);

        seed_mode = 1'b0;
        b0 = fill_bad;
        press(4'b0100);
        frame(780);
        check("clr_len", last_run, 768);
        check("clr_bad", fill_bad - b0, 0);
        check("clr_disp", disp3, 1);
        check("clr_gen", gen3, 0);
        check("clr_ovr", ovr3, 0);
        check("clr_we_off", we3, 0);

        press(4'b1100);
        b0 = fill_bad;
        frame(780);
        check("cs_clr_len", last_run, 768);
        check("cs_clr_bad", fill_bad - b0, 0);
        check("cs_clr_disp", disp3, 0);
        seed_mode = 1'b1;
        o0 = ones;
        frame(780);
        seed_mode = 1'b0;
        check("seed_len", last_run, 768);
        check("seed_bad", fill_bad - b0, 0);
        check("seed_ones", (ones - o0) > 100, 1);
        check("seed_disp", disp3, 1);
        check("seed_gen", gen3, 0);
        frame(780);
        check("seed_once", we3 | (last_run != 768), 0);

        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        press(4'b0001);
        frame(10);
        check("ovr_f1_es", cap1, 0);
        frame(10);
        check("ovr_f2_es", cap1, 1);
        check("ovr_f2_flag", ovr1, 0);
        frame(10);
        check("ovr_f3_flag", ovr1, 1);
        done1 = 1'b1;
        tick(1);
        done1 = 1'b0;
        tick(1);
        check("ovr_swap", {disp1, gen1}, {1'b1, 16'd1});
        frame(1);
        check("ovr_pending_es", cap1, 1);
        check("ovr_src", src1, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_es", es1, 0);
        check("arst_src", src1, 0);
        check("arst_disp", disp1, 0);
        check("arst_we", we1, 0);
        check("arst_addr", addr1, 0);
        check("arst_data", data1, 0);
        check("arst_run", run1, 0);
        check("arst_gen", gen1, 0);
        check("arst_ovr", ovr1, 0);
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gol_scheduler.md
# gol_scheduler

Generation scheduler for the Game of Life datapath. It owns the two cell-buffer banks, picks which bank the display reads, and paces the update engine to vertical blanking. It decodes the four user keys into run/pause, single-step, clear and random-seed commands, and performs clear/seed fills of the back bank itself. It sits between the key inputs, the VGA frame timing and the game_of_life update engine.

## Interface
Parameters:
- COLS, 32, grid width in cells
- ROWS, 24, grid height in cells
- GEN_DIV, 30, frames per generation while running (≥1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- key  in  4  synchronized key levels, 1 = pressed; [0] run/pause, [1] step, [2] clear, [3] seed
- frame_start  in  1  one-cycle pulse at start of vertical blank
- eng_done  in  1  one-cycle pulse: engine finished writing next generation
- eng_start  out  1  one-cycle pulse: engine computes bank eng_src_bank → other bank
- eng_src_bank  out  1  source bank for the engine (= disp_bank at start)
- disp_bank  out  1  bank the display reads
- fill_we  out  1  back-bank write enable during clear/seed
- fill_addr  out  ADDR_W  cell address, row-major, 0..CELLS-1
- fill_data  out  1  cell value written
- running  out  1  free-run mode active
- gen_count  out  16  generation number
- overrun  out  1  sticky: generation trigger lost

## Operation
- Key edges: register previous key; command = rising edge (key & ~key_q). A held key produces one command.
- Pending flags pend_clr, pend_seed, pend_step, pend_gen: set by their event, cleared only when acted on. key[0] edge toggles running directly. key[1] edge sets pend_step only if running=0.
- Frame counter frm_cnt: increments on frame_start when running=1. At GEN_DIV-1 it wraps to 0 and sets pend_gen. If pend_gen is already set, overrun is set instead. Pause clears frm_cnt.
- FSM states: IDLE, START, BUSY, SWAP, FILL, FILL_SWAP.
- IDLE: on frame_start, first match wins: pend_clr → FILL with data 0; pend_seed → FILL with data lfsr[0]; pend_gen or pend_step → START. The consumed flag is cleared. With no frame_start, stay in IDLE.
- START: eng_start=1, eng_src_bank=disp_bank, then BUSY.
- BUSY: wait for eng_done, then SWAP.
- SWAP: toggle disp_bank, gen_count+1 (16-bit wrap), then IDLE.
- FILL: fill_we=1 every cycle; fill_addr counts 0..CELLS-1; bank written = ~disp_bank. After the last address → FILL_SWAP.
- FILL_SWAP: toggle disp_bank, gen_count←0. A clear also clears overrun and frm_cnt. Then IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, reset value 16'hACE1, advances every cycle.
- Width rules: CELLS=COLS*ROWS, ADDR_W=$clog2(CELLS).

## Timing
- Reset values: eng_start 0, eng_src_bank 0, disp_bank 0, fill_we 0, fill_addr 0, fill_data 0, running 0, gen_count 0, overrun 0, all pending flags 0, state IDLE.
- All outputs are registered. frame_start sampled at edge t → eng_start high in cycle t+1.
- eng_done sampled at edge t → disp_bank toggles at edge t+1.
- A fill takes exactly CELLS cycles of fill_we, then one FILL_SWAP cycle. The display sees the new bank from the next frame.
- eng_done outside BUSY is ignored. frame_start outside IDLE only feeds frm_cnt and pend_gen; it never starts work mid-state.
- Simultaneous key edges in one cycle: all flags are set; IDLE priority resolves them over successive frames.
- Reset mid-operation: immediate return to reset values. The engine shares reset_n, so no eng_done is expected afterward.

## Structure
- Shared package gol_pkg: COLS/ROWS defaults, CELLS, ADDR_W, state enum, LFSR taps and reset seed, key index constants.
- Sub-module key_edge: 4-bit rising-edge detector, reused by other key-driven blocks.

## Test plan
- Reset, no keys, 100 frame_start pulses → eng_start never asserted; disp_bank=0; gen_count=0.
- key[0] press, GEN_DIV=3, engine returns eng_done 5 cycles after start → eng_start on every 3rd frame; disp_bank alternates; gen_count=1,2,3.
- Paused, key[1] press → exactly one eng_start on next frame_start; gen_count=1. key[1] while running → no extra generation.
- key[2] → next frame: 768 consecutive fill_we cycles, addr 0..767, data 0, bank ~disp_bank; then disp_bank toggles; gen_count=0; overrun=0.
- key[2] and key[3] in the same cycle → clear fill on frame N, seed fill on frame N+1; seed data matches reference LFSR from 16'hACE1.
- GEN_DIV=1, eng_done withheld for 3 frames → overrun=1; one pend_gen serviced after eng_done. reset_n low during BUSY → all outputs return to reset values asynchronously.
